// File: rtl/object_line_scheduler_m.sv
// rtl/object_line_scheduler_m.sv - scanline object selection scheduler
//
// Purpose: scans NUM_OBJECTS Y positions from Object Memory and builds a list of
// up to MAX_PER_LINE objects overlapping target_yp. The list is double-buffered.
// Optional build macro: OBJECT_SCHED_EARLY_EXIT_EN. When it is defined, the first
// overflowing hit ends the scan early.
//
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   start          - one-cycle request; target_yp sampled with it
//   target_yp      - scanline being prepared
//   obm_addr       - Object Memory index requested
//   obm_yp         - YP byte returned one cycle after obm_addr
//   busy           - scan in progress (through PUBLISH)
//   done           - one-cycle pulse when a list is published
//   slot_index     - published object indices, slot 0 in LSBs
//   slot_valid     - published per-slot valid bits
//   count          - number of valid published slots
//   overflow       - published list omitted at least one hit
module object_line_scheduler_m #(
    parameter int NUM_OBJECTS  = 64,
    parameter int MAX_PER_LINE = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                target_yp,
    output logic [5:0]                obm_addr,
    input  logic [7:0]                obm_yp,
    output logic                      busy,
    output logic                      done,
    output logic [6*MAX_PER_LINE-1:0] slot_index,
    output logic [MAX_PER_LINE-1:0]   slot_valid,
    output logic [3:0]                count,
    output logic                      overflow
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_PUBLISH} state_t;

    localparam logic [5:0] LAST_ADDR = 6'(NUM_OBJECTS - 1);
    localparam logic [3:0] MAX_CNT   = 4'(MAX_PER_LINE);

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]                r_target;
    logic [5:0]                r_addr;
    logic                      r_addr_vld;  // obm_addr carries a request not yet issued
    logic                      r_yp_vld;    // obm_yp holds data for r_yp_idx this cycle
    logic [5:0]                r_yp_idx;
    logic [5:0]                r_wslot [MAX_PER_LINE];
    logic [3:0]                r_wcnt;
    logic                      r_wovf;
    logic                      r_done;
    logic [6*MAX_PER_LINE-1:0] r_slot_index;
    logic [MAX_PER_LINE-1:0]   r_slot_valid;
    logic [3:0]                r_count;
    logic                      r_overflow;

    logic [8:0] w_yp9;
    logic [8:0] w_tgt9;
    logic       w_hit;
    logic       w_room;
    logic       w_last;
    logic       w_ovf_hit;

    // 9-bit compare so an object near 255 never wraps onto low scanlines
    assign w_yp9     = {1'b0, obm_yp};
    assign w_tgt9    = {1'b0, r_target};
    assign w_hit     = (r_state == ST_SCAN) && r_yp_vld &&
                       (w_yp9 <= w_tgt9) && (w_tgt9 < (w_yp9 + 9'd8));
    assign w_room    = (r_wcnt < MAX_CNT);
    assign w_last    = (r_state == ST_SCAN) && r_yp_vld && (r_yp_idx == LAST_ADDR);
    assign w_ovf_hit = w_hit && !w_room;

    assign obm_addr   = r_addr;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign slot_index = r_slot_index;
    assign slot_valid = r_slot_valid;
    assign count      = r_count;
    assign overflow   = r_overflow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
`ifdef OBJECT_SCHED_EARLY_EXIT_EN
                if (w_last || w_ovf_hit) begin
                    w_state_nxt = ST_PUBLISH;
                end
`else
                if (w_last) begin
                    w_state_nxt = ST_PUBLISH;
                end
`endif
            end
            ST_PUBLISH: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_target     <= 8'd0;
            r_addr       <= 6'd0;
            r_addr_vld   <= 1'b0;
            r_yp_vld     <= 1'b0;
            r_yp_idx     <= 6'd0;
            r_wcnt       <= 4'd0;
            r_wovf       <= 1'b0;
            r_done       <= 1'b0;
            r_slot_index <= '0;
            r_slot_valid <= '0;
            r_count      <= 4'd0;
            r_overflow   <= 1'b0;
            for (int i = 0; i < MAX_PER_LINE; i++) begin
                r_wslot[i] <= 6'd0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_target   <= target_yp;
                        r_addr     <= 6'd0;
                        r_addr_vld <= 1'b1;
                        r_yp_vld   <= 1'b0;
                        r_wcnt     <= 4'd0;
                        r_wovf     <= 1'b0;
                        // cleared slots guarantee unused entries publish as zero
                        for (int i = 0; i < MAX_PER_LINE; i++) begin
                            r_wslot[i] <= 6'd0;
                        end
                    end
                end
                ST_SCAN: begin
                    r_yp_vld <= r_addr_vld;
                    r_yp_idx <= r_addr;
                    if (r_addr_vld) begin
                        if (r_addr == LAST_ADDR) begin
                            r_addr_vld <= 1'b0;
                        end else begin
                            r_addr <= r_addr + 6'd1;
                        end
                    end
                    if (w_hit) begin
                        if (w_room) begin
                            for (int i = 0; i < MAX_PER_LINE; i++) begin
                                if (4'(i) == r_wcnt) begin
                                    r_wslot[i] <= r_yp_idx;
                                end
                            end
                            r_wcnt <= r_wcnt + 4'd1;
                        end else begin
                            r_wovf <= 1'b1;
                        end
                    end
                end
                ST_PUBLISH: begin
                    r_yp_vld   <= 1'b0;
                    r_count    <= r_wcnt;
                    r_overflow <= r_wovf;
                    r_done     <= 1'b1;
                    for (int i = 0; i < MAX_PER_LINE; i++) begin
                        r_slot_index[6*i +: 6] <= r_wslot[i];
                        r_slot_valid[i]        <= (4'(i) < r_wcnt);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_object_line_scheduler_m.sv
// tb/tb_object_line_scheduler_m.sv - scoreboard bench for object_line_scheduler_m
module tb_object_line_scheduler_m;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  target_yp;
    logic [5:0]  obm_addr;
    logic [7:0]  obm_yp;
    logic        busy;
    logic        done;
    logic [47:0] slot_index;
    logic [7:0]  slot_valid;
    logic [3:0]  count;
    logic        overflow;

    object_line_scheduler_m #(.NUM_OBJECTS(64), .MAX_PER_LINE(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .target_yp  (target_yp),
        .obm_addr   (obm_addr),
        .obm_yp     (obm_yp),
        .busy       (busy),
        .done       (done),
        .slot_index (slot_index),
        .slot_valid (slot_valid),
        .count      (count),
        .overflow   (overflow)
    );

    typedef struct {
        logic [3:0]  cnt;
        logic        ovf;
        logic [47:0] idx;
        logic [7:0]  vld;
        int          lat;
        int          mark;
    } exp_t;

    exp_t       q[$];
    exp_t       pub;
    logic [7:0] mem [64];
    int         edge_cnt = 0;
    int         total    = 0;
    int         bad      = 0;

`ifdef OBJECT_SCHED_EARLY_EXIT_EN
    localparam int OVF_LAT = 11;
`else
    localparam int OVF_LAT = 66;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Object Memory model: one-cycle read latency
    always @(posedge clk) obm_yp <= mem[obm_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops on every done; between dones the published view must not move
    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done at edge %0d", edge_cnt);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("count", 64'(count), 64'(e.cnt));
                    chk("overflow", 64'(overflow), 64'(e.ovf));
                    chk("slot_index", 64'(slot_index), 64'(e.idx));
                    chk("slot_valid", 64'(slot_valid), 64'(e.vld));
                    chk("done_latency", 64'(edge_cnt - (e.mark + 1)), 64'(e.lat));
                    chk("busy_after_publish", 64'(busy), 64'd0);
                    pub = e;
                end
            end else if (busy) begin
                chk("stable_count", 64'(count), 64'(pub.cnt));
                chk("stable_slot_index", 64'(slot_index), 64'(pub.idx));
                chk("stable_slot_valid", 64'(slot_valid), 64'(pub.vld));
                chk("stable_overflow", 64'(overflow), 64'(pub.ovf));
            end
        end
    end

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 64; i++) mem[i] = v;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_obm_addr"}, 64'(obm_addr), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_slot_valid"}, 64'(slot_valid), 64'd0);
        chk({tag, "_slot_index"}, 64'(slot_index), 64'd0);
    endtask

    // Issues one accepted scan, optionally re-pulses start at cycle ignore_at,
    // optionally asserts reset at cycle rst_at; waits (bounded) for done.
    task automatic scan(input logic [7:0] tgt, input logic [3:0] ecnt, input logic eovf,
                        input logic [47:0] eidx, input logic [7:0] evld, input int elat,
                        input int ignore_at, input int rst_at);
        exp_t e;
        bit   seen;
        @(negedge clk);
        start     = 1'b1;
        target_yp = tgt;
        e.cnt = ecnt; e.ovf = eovf; e.idx = eidx; e.vld = evld; e.lat = elat;
        e.mark = edge_cnt;
        q.push_back(e);
        seen = 0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(negedge clk);
            start     = (i == ignore_at);
            target_yp = (i == ignore_at) ? 8'd0 : tgt;
            if (i == rst_at) begin
                rst = 1'b0;
                #1;
                chk_zero_outputs("mid_reset");
                q.delete();
                pub = '{cnt: 4'd0, ovf: 1'b0, idx: 48'd0, vld: 8'd0, lat: 0, mark: 0};
                repeat (3) @(negedge clk);
                rst = 1'b1;
                repeat (80) @(negedge clk);
                return;
            end
            if (done) seen = 1;
        end
        start = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout target=%0d", tgt);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        target_yp = 8'd0;
        pub       = '{cnt: 4'd0, ovf: 1'b0, idx: 48'd0, vld: 8'd0, lat: 0, mark: 0};
        fill_mem(8'd200);
        #1;
        chk_zero_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // no hits
        scan(8'd10, 4'd0, 1'b0, 48'd0, 8'h00, 66, -1, -1);

        // three hits, including last object; top edge of window
        mem[3] = 8'd40; mem[17] = 8'd40; mem[63] = 8'd40;
        scan(8'd47, 4'd3, 1'b0, {30'd0, 6'd63, 6'd17, 6'd3}, 8'h07, 66, -1, -1);
        scan(8'd48, 4'd0, 1'b0, 48'd0, 8'h00, 66, -1, -1);
        // bottom edge of window, plus ignored start mid-scan
        scan(8'd40, 4'd3, 1'b0, {30'd0, 6'd63, 6'd17, 6'd3}, 8'h07, 66, 30, -1);
        repeat (80) @(negedge clk);

        // overflow: ten hits, first eight kept
        fill_mem(8'd200);
        for (int i = 0; i < 10; i++) mem[i] = 8'd0;
        scan(8'd5, 4'd8, 1'b1,
             {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0}, 8'hFF, OVF_LAT, -1, -1);

        // high-end hit without wrap
        fill_mem(8'd200);
        mem[5] = 8'd252;
        scan(8'd255, 4'd1, 1'b0, {42'd0, 6'd5}, 8'h01, 66, -1, -1);
        // YP=255 must not cover low scanlines
        fill_mem(8'd200);
        mem[6] = 8'd255;
        scan(8'd2, 4'd0, 1'b0, 48'd0, 8'h00, 66, -1, -1);

        // reset mid-scan, then a fresh scan
        fill_mem(8'd200);
        mem[9] = 8'd100;
        scan(8'd103, 4'd1, 1'b0, {42'd0, 6'd9}, 8'h01, 66, -1, 20);
        scan(8'd107, 4'd1, 1'b0, {42'd0, 6'd9}, 8'h01, 66, -1, -1);

        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL missing_done pending=%0d", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/object_line_scheduler_m.md
OBJECT_LINE_SCHEDULER_M -- requirements
Module: object_line_scheduler_m

Interface
REQ-001 SHALL have parameter NUM_OBJECTS, default 64: number of Object Memory entries scanned; power of two, 2..64.
REQ-002 SHALL have parameter MAX_PER_LINE, default 8: maximum objects selected per scanline; 1..15.
REQ-003 SHALL have port clk  input  1: single clock; all state on posedge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1: one-cycle request to build the list for target_yp.
REQ-006 SHALL have port target_yp  input  8: scanline being prepared; sampled with start.
REQ-007 SHALL have port obm_addr  output  6: object index whose YP byte is requested.
REQ-008 SHALL have port obm_yp  input  8: YP byte of the object at obm_addr, valid one cycle after obm_addr.
REQ-009 SHALL have port busy  output  1: high while a scan is in progress.
REQ-010 SHALL have port done  output  1: one-cycle pulse when a new list is published.
REQ-011 SHALL have port slot_index  output  6*MAX_PER_LINE: published object indices, slot 0 in the LSBs.
REQ-012 SHALL have port slot_valid  output  MAX_PER_LINE: per-slot valid bits of the published list.
REQ-013 SHALL have port count  output  4: number of valid published slots.
REQ-014 SHALL have port overflow  output  1: published list omitted at least one hit object.

Function
REQ-015 SHALL implement FSM IDLE -> SCAN -> PUBLISH -> IDLE.
REQ-016 IDLE: on start, SHALL latch target_yp, clear the working list and enter SCAN with obm_addr=0.
REQ-017 SCAN: SHALL advance obm_addr by one per cycle from 0 to NUM_OBJECTS-1, then hold.
REQ-018 SCAN: the object whose YP arrives on obm_yp SHALL be a hit when obm_yp <= target_yp < obm_yp+8, evaluated at 9 bits with no wrap.
REQ-019 A hit with working count < MAX_PER_LINE SHALL be written to slot[count], and count SHALL increment.
REQ-020 A hit with working count == MAX_PER_LINE SHALL set working overflow; the stored slots SHALL be unchanged.
REQ-021 Slots SHALL fill in ascending object index, so lower index equals higher priority.
REQ-022 After object NUM_OBJECTS-1 is evaluated, the FSM SHALL enter PUBLISH.
REQ-023 PUBLISH: SHALL copy the working list, count and overflow to the outputs in one cycle, pulse done and return to IDLE.
REQ-024 done SHALL assert exactly NUM_OBJECTS+2 edges after the edge sampling start, in the non-overflow case.
REQ-025 The published outputs SHALL be double-buffered: they change only in PUBLISH and stay stable during the next scan.
REQ-026 start while busy SHALL be ignored; start in the PUBLISH cycle SHALL be ignored.
REQ-027 busy SHALL be high from the cycle after start through the PUBLISH cycle inclusive.
REQ-028 Unused slots SHALL publish slot_valid=0 and slot_index=0.

Reset
REQ-029 Asserting rst SHALL immediately force: FSM to IDLE, busy=0, done=0, obm_addr=0, count=0, overflow=0, all slot_valid=0, all slot_index=0.
REQ-030 Reset mid-scan SHALL discard the working list; no done pulse SHALL follow.
REQ-031 After rst deasserts, the first start SHALL be accepted on the next edge.

Configuration
REQ-032 Macro OBJECT_SCHED_EARLY_EXIT_EN, when defined: the first overflowing hit SHALL end SCAN and enter PUBLISH on the next cycle, so done arrives early.
REQ-033 Without OBJECT_SCHED_EARLY_EXIT_EN: SCAN SHALL always run all NUM_OBJECTS entries, and done latency SHALL be fixed per REQ-024.

Verification
REQ-034 Scenario: all YP=200, target_yp=10, start -> done at edge 66, count=0, slot_valid=0x00, overflow=0.
REQ-035 Scenario: objects 3, 17 and 63 have YP=40, others 200, target_yp=47 -> slots {3,17,63}, count=3, overflow=0; target_yp=48 -> count=0.
REQ-036 Scenario: objects 0..9 have YP=0, target_yp=5 -> slots 0..7, count=8, overflow=1.
  - With OBJECT_SCHED_EARLY_EXIT_EN: done at edge 11.
  - Without it: done at edge 66.
REQ-037 Scenario: object 5 has YP=252, target_yp=255 -> hit; object 6 has YP=255, target_yp=2 -> no hit (no wrap).
REQ-038 Scenario: start again at edge 30 of a scan -> ignored, one done only; published outputs unchanged until edge 66.
REQ-039 Scenario: rst low at edge 20 of a scan -> all outputs zero, no done; a fresh start then completes normally.
